// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel word in, one bit per output beat out, LSB- or MSB-first.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer #(
  parameter int   DATA_WIDTH      = 8,
  parameter bit   SHIFT_DIRECTION = 1'b1,
  parameter logic IDLE_LEVEL      = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  ser_out,
  output logic                  ser_valid,
  output logic                  ser_first,
  output logic                  ser_last,
  input  logic                  ser_ready,
  output logic                  busy
);
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int NB = DATA_WIDTH + 1;
`else
  localparam int NB = DATA_WIDTH;
`endif
  localparam int CW = $clog2(NB);
  localparam logic [CW-1:0] LAST = CW'(NB - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t r_state, w_state_nxt;
  logic [NB-1:0] r_shift, w_word, w_shifted;
  logic [CW-1:0] r_cnt, w_cnt_inc;
  logic r_out, r_valid, r_first, r_last, w_load, w_beat;
  // parity rides at the tail end of the shift register so it leaves after the data bits
`ifdef PISO_SERIALIZER_PARITY_EN
  assign w_word = SHIFT_DIRECTION ? {^data_in, data_in} : {data_in, ^data_in};
`else
  assign w_word = data_in;
`endif
  assign w_shifted = SHIFT_DIRECTION ? r_shift >> 1 : r_shift << 1;
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_beat    = r_valid && ser_ready;
  assign w_load    = in_valid && in_ready;
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  always_comb begin
    in_ready    = !rst && (r_state == IDLE || (r_last && ser_ready));
    w_state_nxt = w_load ? SHIFT : (w_beat && r_last) ? IDLE : r_state;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_out   <= IDLE_LEVEL;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_shift <= w_word;
      r_cnt   <= '0;
      r_out   <= SHIFT_DIRECTION ? w_word[0] : w_word[NB-1];
      r_valid <= 1'b1;
      r_first <= 1'b1;
      r_last  <= 1'b0;
    end else if (w_beat && r_last) begin
      r_cnt   <= '0;
      r_out   <= IDLE_LEVEL;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_beat) begin
      r_shift <= w_shifted;
      r_cnt   <= w_cnt_inc;
      r_out   <= SHIFT_DIRECTION ? w_shifted[0] : w_shifted[NB-1];
      r_first <= 1'b0;
      r_last  <= w_cnt_inc == LAST;
    end
  assign ser_out   = r_out;
  assign ser_valid = r_valid;
  assign ser_first = r_first;
  assign ser_last  = r_last;
  assign busy      = r_valid;
endmodule
